// File: rtl/qdiv_stream_if.sv
// Operand/result handshake bundle for qdiv_stream.
// The slave modport is the divider side and the master modport is the producer/consumer side.
interface qdiv_stream_if #(
  parameter int N = 32
);
  logic         i_valid;
  logic         o_ready;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_valid;
  logic         i_ready;
  logic [N-1:0] o_quotient;
  logic         o_overflow;
  logic         o_div_by_zero;
  logic         o_busy;

  modport slave (
    input  i_valid, i_dividend, i_divisor, i_ready,
    output o_ready, o_valid, o_quotient, o_overflow, o_div_by_zero, o_busy
  );

  modport master (
    output i_valid, i_dividend, i_divisor, i_ready,
    input  o_ready, o_valid, o_quotient, o_overflow, o_div_by_zero, o_busy
  );
endinterface

// File: rtl/qdiv_stream.sv
// Sign-magnitude Q(N,Q) restoring divider with a valid/ready handshake.
// It resolves BPC quotient bits per RUN cycle and detects divide-by-zero and overflow.
module qdiv_stream #(
  parameter int N   = 32,
  parameter int Q   = 15,
  parameter int BPC = 1,
  parameter int SAT = 1
) (
  input  logic          i_clk,
  input  logic          rst,
  qdiv_stream_if.slave  bus
);
  localparam int W    = N - 1 + Q;
  localparam int ITER = (W + BPC - 1) / BPC;
  localparam int WP   = ITER * BPC;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-2:0]    rem_q, rem_d;
  logic [N-2:0]    div_q, div_d;
  logic [WP-1:0]   num_q, num_d;
  logic [WP-1:0]   quo_q, quo_d;
  logic            sign_q, sign_d;
  logic [N-1:0]    res_q, res_d;
  logic            ovf_q, ovf_d;
  logic            dbz_q, dbz_d;

  logic            accept;
  logic            last_iter;
  logic            in_dbz;
  logic [N-2:0]    rem_v;
  logic [WP-1:0]   num_v, quo_v;
  logic [N-1:0]    trial;
  logic            take;
  logic            fin_ovf;
  logic [N-2:0]    fin_mag;
  logic            ready_c, valid_c, busy_c;

  assign accept    = bus.i_valid & (state_q == S_IDLE);
  assign last_iter = (cnt_q == CW'(ITER - 1));
  assign in_dbz    = ~|bus.i_divisor[N-2:0];

  // Numerator is zero-padded at the top when BPC does not divide W; the
  // padding only produces leading zero quotient bits, so the result is unchanged.
  always_comb begin
    rem_v = rem_q;
    num_v = num_q;
    quo_v = quo_q;
    trial = '0;
    take  = 1'b0;
    for (int j = 0; j < BPC; j++) begin
      trial = {rem_v, num_v[WP-1]};
      take  = (trial >= {1'b0, div_q});
      if (take) begin
        trial = trial - {1'b0, div_q};
      end
      rem_v = trial[N-2:0];
      num_v = {num_v[WP-2:0], 1'b0};
      quo_v = {quo_v[WP-2:0], take};
    end
    fin_ovf = |quo_v[W-1:N-1];
    fin_mag = (fin_ovf && (SAT != 0)) ? '1 : quo_v[N-2:0];
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = in_dbz ? S_DONE : S_RUN;
      S_RUN:   if (last_iter) state_d = S_DONE;
      S_DONE:  if (bus.i_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_c = (state_q == S_IDLE);
    valid_c = (state_q == S_DONE);
    busy_c  = (state_q == S_RUN);
  end

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    div_d  = div_q;
    num_d  = num_q;
    quo_d  = quo_q;
    sign_d = sign_q;
    res_d  = res_q;
    ovf_d  = ovf_q;
    dbz_d  = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d          = '0;
          rem_d          = '0;
          quo_d          = '0;
          div_d          = bus.i_divisor[N-2:0];
          num_d          = '0;
          num_d[W-1:0]   = {bus.i_dividend[N-2:0], {Q{1'b0}}};
          sign_d         = bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
          ovf_d          = in_dbz;
          dbz_d          = in_dbz;
          if (in_dbz) begin
            res_d = {bus.i_dividend[N-1] & (|bus.i_dividend[N-2:0]), {(N-1){1'b1}}};
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        rem_d = rem_v;
        num_d = num_v;
        quo_d = quo_v;
        if (last_iter) begin
          ovf_d = fin_ovf;
          res_d = {sign_q & (|fin_mag), fin_mag};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      num_q  <= '0;
      quo_q  <= '0;
      sign_q <= 1'b0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      div_q  <= div_d;
      num_q  <= num_d;
      quo_q  <= quo_d;
      sign_q <= sign_d;
      res_q  <= res_d;
      ovf_q  <= ovf_d;
      dbz_q  <= dbz_d;
    end
  end

  assign bus.o_ready       = ready_c;
  assign bus.o_valid       = valid_c;
  assign bus.o_busy        = busy_c;
  assign bus.o_quotient    = res_q;
  assign bus.o_overflow    = ovf_q;
  assign bus.o_div_by_zero = dbz_q;
endmodule

// File: tb/tb_qdiv_stream.sv
// Bench for qdiv_stream: four instances (BPC 1/2/4 with SAT=1, BPC 4 with SAT=0) share one
// operand stream and are checked against an arithmetic reference model.
module tb_qdiv_stream;
  logic        clk = 1'b0;
  logic        rst;
  logic        d_valid, d_ready;
  logic [31:0] d_dividend, d_divisor;

  logic [3:0]  ov_a, or_a, ovf_a, dbz_a, busy_a;
  logic [31:0] quo_a [4];

  int          n_tests = 0;
  int          n_fail  = 0;

  logic [31:0] got_q   [4];
  logic        got_ovf [4];
  logic        got_dbz [4];
  logic        got_seen[4];
  int          got_lat [4];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 4; gi++) begin : g_dut
    localparam int BPC_G = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    localparam int SAT_G = (gi == 3) ? 0 : 1;
    qdiv_stream_if #(.N(32)) bus ();
    assign bus.i_valid    = d_valid;
    assign bus.i_dividend = d_dividend;
    assign bus.i_divisor  = d_divisor;
    assign bus.i_ready    = d_ready;
    assign ov_a[gi]       = bus.o_valid;
    assign or_a[gi]       = bus.o_ready;
    assign ovf_a[gi]      = bus.o_overflow;
    assign dbz_a[gi]      = bus.o_div_by_zero;
    assign busy_a[gi]     = bus.o_busy;
    assign quo_a[gi]      = bus.o_quotient;
    qdiv_stream #(.N(32), .Q(15), .BPC(BPC_G), .SAT(SAT_G)) u_dut (
      .i_clk (clk),
      .rst   (rst),
      .bus   (bus)
    );
  end

  function automatic int bpc_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
  endfunction

  function automatic int sat_of(input int k);
    return (k == 3) ? 0 : 1;
  endfunction

  function automatic int lat_of(input int k, input logic dbz);
    return dbz ? 1 : ((46 + bpc_of(k) - 1) / bpc_of(k) + 1);
  endfunction

  // Reference: {dbz, ovf, quotient} from plain integer division of the magnitudes.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input int sat);
    longint unsigned am, bm, m;
    logic [30:0]     mag;
    logic            ovf;
    am = 64'(a[30:0]);
    bm = 64'(b[30:0]);
    if (bm == 0) return {1'b1, 1'b1, a[31] & (am != 0), 31'h7FFFFFFF};
    m   = (am << 15) / bm;
    ovf = (m > 64'h7FFFFFFF);
    mag = (ovf && sat == 1) ? 31'h7FFFFFFF : m[30:0];
    return {1'b0, ovf, (a[31] ^ b[31]) & (mag != 0), mag};
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b);
    d_dividend = a;
    d_divisor  = b;
    d_ready    = 1'b1;
    d_valid    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got_seen[k] = 1'b0;
      got_lat[k]  = 0;
    end
    for (int c = 1; c <= 52; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        d_valid    = 1'b0;
        d_dividend = $urandom;
        d_divisor  = $urandom;
      end
      for (int k = 0; k < 4; k++) begin
        if (ov_a[k] && !got_seen[k]) begin
          got_seen[k] = 1'b1;
          got_lat[k]  = c;
          got_q[k]    = quo_a[k];
          got_ovf[k]  = ovf_a[k];
          got_dbz[k]  = dbz_a[k];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (or_a !== 4'hF || ov_a !== 4'h0 || busy_a !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_handshake: ready=%b valid=%b busy=%b, want 1111/0000/0000", or_a, ov_a, busy_a);
    end
    n_tests++;
    if (ovf_a !== 4'h0 || dbz_a !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_flags: ovf=%b dbz=%b, want 0000/0000", ovf_a, dbz_a);
    end
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (quo_a[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_quotient dut%0d: got %h want 00000000", k, quo_a[k]);
      end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset checked");
  endtask

  task automatic test_directed();
    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [33:0] e;
    ta = '{32'h00018000, 32'h80018000, 32'h80000000, 32'h80000000, 32'h7FFFFFFF,
           32'h80010000, 32'h0000FFFF, 32'h80010000, 32'h00000000, 32'h00010000};
    tb = '{32'h00010000, 32'h00010000, 32'h80028000, 32'h00028000, 32'h00000001,
           32'h00000001, 32'h00000001, 32'h80000000, 32'h00000000, 32'h7FFFFFFF};
    for (int i = 0; i < 10; i++) begin
      run_txn(ta[i], tb[i]);
      for (int k = 0; k < 4; k++) begin
        e = model(ta[i], tb[i], sat_of(k));
        n_tests++;
        if (got_seen[k] !== 1'b1 || got_lat[k] !== lat_of(k, e[33])) begin
          n_fail++;
          $display("FAIL dir%0d_latency dut%0d: got %0d (seen %b) want %0d", i, k, got_lat[k], got_seen[k], lat_of(k, e[33]));
        end
        n_tests++;
        if (got_q[k] !== e[31:0]) begin
          n_fail++;
          $display("FAIL dir%0d_quotient dut%0d: got %h want %h", i, k, got_q[k], e[31:0]);
        end
        n_tests++;
        if ({got_dbz[k], got_ovf[k]} !== e[33:32]) begin
          n_fail++;
          $display("FAIL dir%0d_flags dut%0d: dbz/ovf got %b%b want %b", i, k, got_dbz[k], got_ovf[k], e[33:32]);
        end
      end
      if (i == 0) begin
        for (int k = 0; k < 4; k++) begin
          n_tests++;
          if (got_q[k] !== 32'h0000C000) begin
            n_fail++;
            $display("FAIL three_over_two dut%0d: got %h want 0000C000", k, got_q[k]);
          end
        end
      end
      $display("[TB] directed %h / %h -> %h %h %h %h", ta[i], tb[i], got_q[0], got_q[1], got_q[2], got_q[3]);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [33:0] e;
    int          r;
    for (int i = 0; i < 24; i++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (r == 0) b = b & 32'h80000000;
      else if (r < 4) b = b & 32'h8000FFFF;
      if (r == 5) a = a & 32'h8000FFFF;
      run_txn(a, b);
      for (int k = 0; k < 4; k++) begin
        e = model(a, b, sat_of(k));
        n_tests++;
        if (got_seen[k] !== 1'b1 || got_lat[k] !== lat_of(k, e[33])) begin
          n_fail++;
          $display("FAIL rnd%0d_latency dut%0d: got %0d (seen %b) want %0d", i, k, got_lat[k], got_seen[k], lat_of(k, e[33]));
        end
        n_tests++;
        if (got_q[k] !== e[31:0] || {got_dbz[k], got_ovf[k]} !== e[33:32]) begin
          n_fail++;
          $display("FAIL rnd%0d_result dut%0d: %h/%h got %h dbz/ovf %b%b want %h %b", i, k, a, b, got_q[k], got_dbz[k], got_ovf[k], e[31:0], e[33:32]);
        end
      end
      $display("[TB] random %h / %h -> %h %h %h %h", a, b, got_q[0], got_q[1], got_q[2], got_q[3]);
    end
  endtask

  task automatic test_stall();
    int waited;
    d_dividend = 32'h00018000;
    d_divisor  = 32'h00010000;
    d_ready    = 1'b0;
    d_valid    = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    waited  = 0;
    while (ov_a !== 4'hF && waited < 60) begin
      @(posedge clk); #1;
      waited++;
    end
    n_tests++;
    if (ov_a !== 4'hF) begin
      n_fail++;
      $display("FAIL stall_wait: o_valid=%b after %0d cycles, want 1111", ov_a, waited);
    end
    d_valid    = 1'b1;
    d_dividend = 32'h00050000;
    d_divisor  = 32'h00001000;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_tests++;
      if (ov_a !== 4'hF || or_a !== 4'h0) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b ready=%b want 1111/0000", c, ov_a, or_a);
      end
      for (int k = 0; k < 4; k++) begin
        n_tests++;
        if (quo_a[k] !== 32'h0000C000 || ovf_a[k] !== 1'b0 || dbz_a[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_data%0d dut%0d: got %h ovf %b dbz %b want 0000C000 0 0", c, k, quo_a[k], ovf_a[k], dbz_a[k]);
        end
      end
    end
    d_ready = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    n_tests++;
    if (ov_a !== 4'h0 || or_a !== 4'hF) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b ready=%b want 0000/1111", ov_a, or_a);
    end
    $display("[TB] stall of 5 cycles checked");
  endtask

  task automatic test_flags();
    run_txn(32'h80010000, 32'h80000000);
    n_tests++;
    if (dbz_a !== 4'hF || ovf_a !== 4'hF || or_a !== 4'hF) begin
      n_fail++;
      $display("FAIL flags_persist: dbz=%b ovf=%b ready=%b want 1111/1111/1111", dbz_a, ovf_a, or_a);
    end
    d_dividend = 32'h00018000;
    d_divisor  = 32'h00010000;
    d_valid    = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    n_tests++;
    if (dbz_a !== 4'h0 || ovf_a !== 4'h0 || busy_a !== 4'hF) begin
      n_fail++;
      $display("FAIL flags_clear: dbz=%b ovf=%b busy=%b want 0000/0000/1111", dbz_a, ovf_a, busy_a);
    end
    repeat (52) @(posedge clk);
    #1;
    $display("[TB] flag lifetime checked");
  endtask

  task automatic test_back_to_back();
    int          last[4];
    int          cnt[4];
    logic [33:0] e;
    d_dividend = 32'h80123456;
    d_divisor  = 32'h00004321;
    d_ready    = 1'b1;
    d_valid    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      last[k] = -1;
      cnt[k]  = 0;
    end
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        if (ov_a[k]) begin
          e = model(d_dividend, d_divisor, sat_of(k));
          n_tests++;
          if (or_a[k] !== 1'b0 || quo_a[k] !== e[31:0]) begin
            n_fail++;
            $display("FAIL b2b_result dut%0d: ready %b quotient %h want 0 %h", k, or_a[k], quo_a[k], e[31:0]);
          end
          if (last[k] >= 0) begin
            n_tests++;
            if (c - last[k] !== lat_of(k, 1'b0) + 1) begin
              n_fail++;
              $display("FAIL b2b_period dut%0d: got %0d want %0d", k, c - last[k], lat_of(k, 1'b0) + 1);
            end
          end
          last[k] = c;
          cnt[k]++;
        end
      end
    end
    d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (cnt[k] < 2) begin
        n_fail++;
        $display("FAIL b2b_count dut%0d: got %0d results want at least 2", k, cnt[k]);
      end
    end
    repeat (52) @(posedge clk);
    #1;
    $display("[TB] back-to-back counts %0d %0d %0d %0d", cnt[0], cnt[1], cnt[2], cnt[3]);
  endtask

  task automatic test_reset_midrun();
    logic [3:0] seen;
    d_dividend = 32'h00018000;
    d_divisor  = 32'h00010000;
    d_ready    = 1'b1;
    d_valid    = 1'b1;
    @(posedge clk); #1;
    d_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_tests++;
    if (ov_a !== 4'h0 || or_a !== 4'hF || busy_a !== 4'h0) begin
      n_fail++;
      $display("FAIL midrun_reset: valid=%b ready=%b busy=%b want 0000/1111/0000", ov_a, or_a, busy_a);
    end
    seen = 4'h0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      seen = seen | ov_a;
    end
    n_tests++;
    if (seen !== 4'h0) begin
      n_fail++;
      $display("FAIL midrun_stale: o_valid seen %b want 0000", seen);
    end
    $display("[TB] reset during RUN checked");
  endtask

  initial begin
    rst        = 1'b0;
    d_valid    = 1'b0;
    d_ready    = 1'b1;
    d_dividend = 32'h0;
    d_divisor  = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_flags();
    test_back_to_back();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
